load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the byte-addressed data memory (enable/write_enable/addr/byte_enable port, 1-cycle registered read).
//  Accepts one RV32I load/store per request handshake and computes the effective address.
//  Issues the memory access, then sign- or zero-extends load data and returns a single response.
//  Sits between execute stage and data memory; one outstanding operation at a time.
// PARAMETERS
//  ADDR_WIDTH  8  memory address width; memory holds 2**ADDR_WIDTH bytes
// PORTS
//  clk               in   1           rising-edge clock
//  rst               in   1           synchronous reset, active-high
//  req_valid         in   1           request present
//  req_ready         out  1           LSU can accept request (state IDLE and !rst)
//  req_write         in   1           1=store, 0=load
//  req_funct3        in   3           000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
//  req_base          in   32          rs1 value
//  req_offset        in   12          signed immediate
//  req_wdata         in   32          rs2 value (stores)
//  resp_valid        out  1           response held until accepted
//  resp_ready        in   1           consumer takes response
//  resp_rdata        out  32          extended load data; 0 for stores/faults
//  resp_fault        out  1           access rejected, memory untouched
//  mem_enable        out  1           memory access strobe
//  mem_write_enable  out  1           1=write
//  mem_addr          out  ADDR_WIDTH  byte address (lowest byte of access)
//  mem_byte_enable   out  2           00 byte, 01 half, 11 word (byte 0 always written)
//  mem_wdata         out  32          store data, byte at addr = bits[7:0]
//  mem_rdata         in   32          {mem[a+3],mem[a+2],mem[a+1],mem[a]}, valid cycle after enable
// BEHAVIOUR
//  Reset: state IDLE; resp_valid, resp_fault, mem_enable, mem_write_enable = 0; resp_rdata, mem_addr,
//   mem_byte_enable, mem_wdata = 0. All outputs registered except req_ready.
//  EA = req_base + sign_extend(req_offset), 32-bit wrap. size = 1/2/4 from funct3[1:0].
//  Fault if: funct3 in {011,110,111}; store with funct3[2]=1; EA[31:ADDR_WIDTH] != 0;
//   EA[ADDR_WIDTH-1:0] + size - 1 > 2**ADDR_WIDTH - 1 (no wrap past top). Misalignment is NOT a fault.
//  FSM:
//   IDLE    : req_valid&&req_ready -> capture op; fault ? RESP(fault=1) : ISSUE.
//   ISSUE   : exactly one cycle, mem_enable=1, mem_write_enable=req_write, addr/byte_enable/wdata driven.
//             store -> RESP ; load -> CAPTURE.
//   CAPTURE : sample mem_rdata, extend by funct3 (B/H sign from bit 7/15, BU/HU zero, W as-is) into resp_rdata -> RESP.
//   RESP    : resp_valid=1, outputs stable; resp_ready -> IDLE (resp_valid low next cycle).
//  mem_enable low in all states but ISSUE; mem_addr/byte_enable/wdata may hold last values when idle.
//  Latency from accept edge: store/fault resp_valid 2nd cycle after (1 cycle for fault path = next cycle);
//   precisely: fault resp_valid cycle t+1, store t+2, load t+3. req_ready returns the cycle after resp handshake.
//  resp_valid && resp_ready with req_valid high same cycle: request NOT accepted (req_ready is 0 in RESP).
//  rst in ISSUE: memory samples mem_enable on the same edge, so that access completes (a store commits);
//   LSU still returns to IDLE, no response issued.
//  rst in RESP: response dropped, resp_valid 0 next cycle.
// TESTING
//  SW base=0x10 off=0x4 wdata=0xDEADBEEF -> mem_enable 1 cycle, addr 0x14, byte_en 11, resp at t+2, fault 0.
//  After above, LB off=0x14 base=0 -> addr 0x14, resp_rdata=0xFFFFFFEF at t+3; LBU -> 0x000000EF; LH -> 0xFFFFBEEF.
//  SB base=0x20 wdata=0x12345678 then LW 0x20 -> byte0=0x78, bytes1-3 unchanged (byte_en 00).
//  LW base=0xFE -> fault (crosses top), no mem_enable ever; base=0x100 or funct3=011 -> fault; SB funct3=100 -> fault.
//  Negative offset: base=0x30 off=0xFFC LW -> addr 0x2C; unaligned LH at 0x21 allowed, returns {mem[0x22],mem[0x21]} extended.
//  Hold resp_ready=0 5 cycles -> resp_valid/rdata stable, req_ready 0; pulse rst during ISSUE of SW -> IDLE next cycle, no resp, memory written.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one operation in flight, computes the effective address,
// drives a byte-addressed memory with a 1-cycle registered read, and extends load data.
module load_store_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_base,
  input  logic [11:0]           req_offset,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_byte_enable,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  op_write_q, op_write_d;
  logic [2:0]            op_funct3_q, op_funct3_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_fault_q, resp_fault_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_enable_q, mem_write_enable_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]            mem_byte_enable_q, mem_byte_enable_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [31:0]           ea;
  logic [1:0]            size_m1;
  logic [ADDR_WIDTH:0]   last_byte;
  logic                  bad_funct3;
  logic                  out_of_range;
  logic                  crosses_top;
  logic                  req_fault;
  logic                  accept;
  logic [31:0]           load_ext;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Address check and fault decode for the request currently on the port.
  always_comb begin
    ea = req_base + {{20{req_offset[11]}}, req_offset};
    case (req_funct3[1:0])
      2'b01:   size_m1 = 2'd1;
      2'b10:   size_m1 = 2'd3;
      default: size_m1 = 2'd0;
    endcase
    // One extra bit catches an access whose last byte runs past the top of memory.
    last_byte    = {1'b0, ea[ADDR_WIDTH-1:0]} + {{(ADDR_WIDTH-1){1'b0}}, size_m1};
    crosses_top  = last_byte[ADDR_WIDTH];
    out_of_range = |ea[31:ADDR_WIDTH];
    bad_funct3   = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110)
                || (req_write && req_funct3[2]);
    req_fault    = bad_funct3 || out_of_range || crosses_top;
  end

  always_comb begin
    case (op_funct3_q)
      3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_ext = {24'h0, mem_rdata[7:0]};
      3'b101:  load_ext = {16'h0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q (or a fixed value) so no branch leaves one unassigned and infers a latch.
    state_d            = state_q;
    op_write_d         = op_write_q;
    op_funct3_d        = op_funct3_q;
    resp_valid_d       = resp_valid_q;
    resp_rdata_d       = resp_rdata_q;
    resp_fault_d       = resp_fault_q;
    mem_enable_d       = 1'b0;
    mem_write_enable_d = 1'b0;
    mem_addr_d         = mem_addr_q;
    mem_byte_enable_d  = mem_byte_enable_q;
    mem_wdata_d        = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_write_d   = req_write;
          op_funct3_d  = req_funct3;
          resp_rdata_d = '0;
          resp_fault_d = req_fault;
          if (req_fault) begin
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            mem_enable_d       = 1'b1;
            mem_write_enable_d = req_write;
            mem_addr_d         = ea[ADDR_WIDTH-1:0];
            mem_byte_enable_d  = {req_funct3[1], req_funct3[1] | req_funct3[0]};
            mem_wdata_d        = req_wdata;
            state_d            = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_write_q) begin
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        resp_rdata_d = load_ext;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (rst) begin
      state_q            <= IDLE;
      op_write_q         <= 1'b0;
      op_funct3_q        <= '0;
      resp_valid_q       <= 1'b0;
      resp_rdata_q       <= '0;
      resp_fault_q       <= 1'b0;
      mem_enable_q       <= 1'b0;
      mem_write_enable_q <= 1'b0;
      mem_addr_q         <= '0;
      mem_byte_enable_q  <= '0;
      mem_wdata_q        <= '0;
    end else begin
      state_q            <= state_d;
      op_write_q         <= op_write_d;
      op_funct3_q        <= op_funct3_d;
      resp_valid_q       <= resp_valid_d;
      resp_rdata_q       <= resp_rdata_d;
      resp_fault_q       <= resp_fault_d;
      mem_enable_q       <= mem_enable_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_addr_q         <= mem_addr_d;
      mem_byte_enable_q  <= mem_byte_enable_d;
      mem_wdata_q        <= mem_wdata_d;
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_fault       = resp_fault_q;
  assign mem_enable       = mem_enable_q;
  assign mem_write_enable = mem_write_enable_q;
  assign mem_addr         = mem_addr_q;
  assign mem_byte_enable  = mem_byte_enable_q;
  assign mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte memory model, a response scoreboard
// fed by the stimulus, and per-operation checks of memory strobes and latency.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_enable;
  logic        mem_write_enable;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  logic [7:0] mem [256];

  load_store_unit #(.ADDR_WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_base         (req_base),
    .req_offset       (req_offset),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_enable       (mem_enable),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_byte_enable  (mem_byte_enable),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: byte writes per byte_enable, registered 4-byte read.
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_write_enable) begin
        mem[mem_addr] <= mem_wdata[7:0];
        if (mem_byte_enable[0]) mem[8'(mem_addr + 8'd1)] <= mem_wdata[15:8];
        if (mem_byte_enable[1]) begin
          mem[8'(mem_addr + 8'd2)] <= mem_wdata[23:16];
          mem[8'(mem_addr + 8'd3)] <= mem_wdata[31:24];
        end
      end else begin
        mem_rdata <= {mem[8'(mem_addr + 8'd3)], mem[8'(mem_addr + 8'd2)],
                      mem[8'(mem_addr + 8'd1)], mem[mem_addr]};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check({sb_e.name, "_fault"}, {31'd0, resp_fault}, {31'd0, sb_e.fault});
        check({sb_e.name, "_rdata"}, resp_rdata, sb_e.rdata);
      end
    end
  end

  task automatic wait_ready(input string name, output logic ok);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] base, input logic [11:0] off, input logic [31:0] wdata,
                       input logic exp_fault, input logic [31:0] exp_rdata,
                       input logic [7:0] exp_addr, input logic [1:0] exp_be, input int hold);
    logic        ok, done, stable_ok, f0, gwe;
    logic [31:0] r0, gwd;
    logic [7:0]  ga;
    logic [1:0]  gbe;
    int          lat, en, held, exp_lat;
    wait_ready(name, ok);
    if (!ok) return;
    exp_lat    = exp_fault ? 1 : (wr ? 2 : 3);
    req_write  = wr;
    req_funct3 = f3;
    req_base   = base;
    req_offset = off;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    sb_q.push_back('{fault: exp_fault, rdata: exp_rdata, name: name});
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; en = 0; held = 0; done = 1'b0; stable_ok = 1'b1;
    r0 = '0; f0 = 1'b0; ga = '0; gbe = '0; gwe = 1'b0; gwd = '0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (mem_enable) begin
        en++;
        ga  = mem_addr;
        gbe = mem_byte_enable;
        gwe = mem_write_enable;
        gwd = mem_wdata;
      end
      if (resp_valid) begin
        if (lat == 0) begin
          lat = k;
          r0  = resp_rdata;
          f0  = resp_fault;
        end
        if (resp_rdata !== r0 || resp_fault !== f0 || req_ready !== 1'b0) stable_ok = 1'b0;
        if (resp_ready) begin
          done = 1'b1;
        end else begin
          held++;
          if (held >= hold) begin
            @(posedge clk);
            #1 resp_ready = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_mem_en_cycles"}, en, exp_fault ? 0 : 1);
    check({name, "_resp_stable"}, {31'd0, stable_ok}, 32'd1);
    if (!exp_fault) begin
      check({name, "_addr"}, {24'd0, ga}, {24'd0, exp_addr});
      check({name, "_byte_en"}, {30'd0, gbe}, {30'd0, exp_be});
      check({name, "_write_en"}, {31'd0, gwe}, {31'd0, wr});
      if (wr) check({name, "_wdata"}, gwd, wdata);
    end
    if (hold > 0) check({name, "_held_cycles"}, held, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    logic quiet;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem_rdata  = '0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = '0;
    req_base   = '0;
    req_offset = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_be", {30'd0, mem_byte_enable}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    //    name          wr    f3      base          off      wdata          flt   rdata          addr   be     hold
    do_op("sw",         1'b1, 3'b010, 32'h10,       12'h004, 32'hDEADBEEF, 1'b0, 32'h0,        8'h14, 2'b11, 0);
    do_op("lb",         1'b0, 3'b000, 32'h0,        12'h014, 32'h0,        1'b0, 32'hFFFFFFEF, 8'h14, 2'b00, 0);
    do_op("lbu",        1'b0, 3'b100, 32'h0,        12'h014, 32'h0,        1'b0, 32'h000000EF, 8'h14, 2'b00, 0);
    do_op("lh",         1'b0, 3'b001, 32'h0,        12'h014, 32'h0,        1'b0, 32'hFFFFBEEF, 8'h14, 2'b01, 0);
    do_op("lw",         1'b0, 3'b010, 32'h0,        12'h014, 32'h0,        1'b0, 32'hDEADBEEF, 8'h14, 2'b11, 0);
    do_op("sb",         1'b1, 3'b000, 32'h20,       12'h000, 32'h12345678, 1'b0, 32'h0,        8'h20, 2'b00, 0);
    do_op("lw_after_sb",1'b0, 3'b010, 32'h20,       12'h000, 32'h0,        1'b0, 32'h23222178, 8'h20, 2'b11, 0);
    do_op("lw_neg_off", 1'b0, 3'b010, 32'h30,       12'hFFC, 32'h0,        1'b0, 32'h2F2E2D2C, 8'h2C, 2'b11, 0);
    do_op("lh_unal",    1'b0, 3'b001, 32'h21,       12'h000, 32'h0,        1'b0, 32'h00002221, 8'h21, 2'b01, 0);
    do_op("lh_unal_neg",1'b0, 3'b001, 32'h15,       12'h000, 32'h0,        1'b0, 32'hFFFFADBE, 8'h15, 2'b01, 0);
    do_op("lhu_unal",   1'b0, 3'b101, 32'h15,       12'h000, 32'h0,        1'b0, 32'h0000ADBE, 8'h15, 2'b01, 0);
    do_op("lw_top_ok",  1'b0, 3'b010, 32'hFC,       12'h000, 32'h0,        1'b0, 32'hFFFEFDFC, 8'hFC, 2'b11, 0);
    do_op("lb_top_ok",  1'b0, 3'b000, 32'hFF,       12'h000, 32'h0,        1'b0, 32'hFFFFFFFF, 8'hFF, 2'b00, 0);
    do_op("lw_cross",   1'b0, 3'b010, 32'hFE,       12'h000, 32'h0,        1'b1, 32'h0,        8'h00, 2'b00, 0);
    do_op("lh_cross",   1'b0, 3'b001, 32'hFF,       12'h000, 32'h0,        1'b1, 32'h0,        8'h00, 2'b00, 0);
    do_op("lb_oor",     1'b0, 3'b000, 32'h100,      12'h000, 32'h0,        1'b1, 32'h0,        8'h00, 2'b00, 0);
    do_op("lw_neg_ea",  1'b0, 3'b010, 32'h0,        12'hFFF, 32'h0,        1'b1, 32'h0,        8'h00, 2'b00, 0);
    do_op("f3_011",     1'b0, 3'b011, 32'h10,       12'h000, 32'h0,        1'b1, 32'h0,        8'h00, 2'b00, 0);
    do_op("f3_110",     1'b0, 3'b110, 32'h10,       12'h000, 32'h0,        1'b1, 32'h0,        8'h00, 2'b00, 0);
    do_op("sb_f3_100",  1'b1, 3'b100, 32'h10,       12'h000, 32'hFFFFFFFF, 1'b1, 32'h0,        8'h00, 2'b00, 0);
    do_op("lw_hold",    1'b0, 3'b010, 32'h14,       12'h000, 32'h0,        1'b0, 32'hDEADBEEF, 8'h14, 2'b11, 5);
    do_op("fault_hold", 1'b0, 3'b111, 32'h14,       12'h000, 32'h0,        1'b1, 32'h0,        8'h00, 2'b00, 5);

    // Reset pulsed during ISSUE of a store: the write still lands, no response follows.
    wait_ready("rst_issue", ok);
    if (ok) begin
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_base   = 32'h40;
      req_offset = 12'h000;
      req_wdata  = 32'hCAFEF00D;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_issue_mem_en", {31'd0, mem_enable}, 32'd1);
      check("rst_issue_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      quiet = 1'b1;
      @(negedge clk);
      check("rst_issue_idle", {31'd0, req_ready}, 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (resp_valid || mem_enable) quiet = 1'b0;
        @(negedge clk);
      end
      check("rst_issue_no_resp", {31'd0, quiet}, 32'd1);
    end
    do_op("lw_after_rst", 1'b0, 3'b010, 32'h40, 12'h000, 32'h0, 1'b0, 32'hCAFEF00D, 8'h40, 2'b11, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
